// File: rtl/bin_to_bcd_pkg.sv
// bin_to_bcd_pkg
//   Shared types and helpers for the sequential binary-to-BCD converter.
//   - state_t        : converter FSM states (IDLE, SHIFT, DONE)
//   - bcd_digits_for : minimum BCD digit count for a binary width, used by
//                      the converter's elaboration check and by tops that
//                      size the DIGITS parameter.
package bin_to_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Largest magnitude is 2^width-1 (unsigned) or 2^(width-1) (signed, the
  // magnitude of the most negative value).
  function automatic int unsigned bcd_digits_for(input int unsigned width,
                                                 input bit          is_signed);
    longint unsigned maxv;
    longint unsigned pow;
    int unsigned     d;
    if (is_signed) maxv = 64'd1 << (width - 1);
    else           maxv = (64'd1 << width) - 64'd1;
    pow = 64'd1;
    d   = 0;
    while (pow <= maxv) begin
      pow = pow * 64'd10;
      d   = d + 1;
    end
    if (d == 0) d = 1;
    return d;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_adj.sv
// bcd_digit_adj
//   Combinational double-dabble correction cell for one BCD digit:
//   q = d + 3 when d >= 5, otherwise q = d.
//   Ports:
//     d  in  4  scratch digit before the shift
//     q  out 4  corrected digit
module bcd_digit_adj (
  input  logic [3:0] d,
  output logic [3:0] q
);

  always_comb begin
    q = d;
    if (d >= 4'd5) q = d + 4'd3;
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq
//   Sequential binary-to-BCD converter (shift-and-add-3), one operand bit
//   per clock, with a start/busy/valid handshake.
//   Parameters:
//     BIN_W   binary input width (4..32)
//     DIGITS  number of BCD output digits
//   Ports:
//     i_clk    in   1         clock, rising edge
//     i_rst    in   1         synchronous active-high reset
//     i_start  in   1         conversion request, sampled only in IDLE
//     i_bin    in   BIN_W     operand, captured on the accepting edge
//     o_busy   out  1         conversion in progress
//     o_valid  out  1         one-cycle pulse, o_bcd updated this cycle
//     o_bcd    out  4*DIGITS  packed BCD result, digit 0 in [3:0]
//     o_neg    out  1         result sign (only with BIN_TO_BCD_SIGNED_EN)
//   Build option:
//     BIN_TO_BCD_SIGNED_EN  treat i_bin as two's complement; converts the
//                           magnitude and reports the sign on o_neg.
module bin_to_bcd_seq
  import bin_to_bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [BIN_W-1:0]      i_bin,
  output logic                  o_busy,
  output logic                  o_valid,
`ifdef BIN_TO_BCD_SIGNED_EN
  output logic                  o_neg,
`endif
  output logic [4*DIGITS-1:0]   o_bcd
);

  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam int unsigned SCR_W = 4 * DIGITS;
`ifdef BIN_TO_BCD_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  if (BIN_W < 4 || BIN_W > 32) begin : g_bad_width
    $error("bin_to_bcd_seq: BIN_W must be in 4..32");
  end
  if (DIGITS < bcd_digits_for(BIN_W, SIGNED_EN)) begin : g_bad_digits
    $error("bin_to_bcd_seq: DIGITS too small for BIN_W");
  end

  state_t             state, next_state;
  logic [BIN_W-1:0]   opr;
  logic [SCR_W-1:0]   scr;
  logic [SCR_W-1:0]   scr_adj;
  logic [CNT_W-1:0]   cnt;
  logic [BIN_W-1:0]   load_val;

`ifdef BIN_TO_BCD_SIGNED_EN
  logic neg_r;
  // Unsigned BIN_W-bit negation: the most negative value maps to 2^(BIN_W-1).
  assign load_val = i_bin[BIN_W-1] ? (~i_bin + BIN_W'(1)) : i_bin;
`else
  assign load_val = i_bin;
`endif

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d (scr[4*g +: 4]),
      .q (scr_adj[4*g +: 4])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= next_state;
  end

  // SHIFT spends BIN_W cycles shifting plus one cycle seeing cnt==0.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (i_start) next_state = SHIFT;
      SHIFT:   if (cnt == '0) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      opr     <= '0;
      scr     <= '0;
      cnt     <= '0;
      o_busy  <= 1'b0;
      o_valid <= 1'b0;
      o_bcd   <= '0;
`ifdef BIN_TO_BCD_SIGNED_EN
      neg_r   <= 1'b0;
      o_neg   <= 1'b0;
`endif
    end else begin
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            opr <= load_val;
            scr <= '0;
            cnt <= CNT_W'(BIN_W);
`ifdef BIN_TO_BCD_SIGNED_EN
            neg_r <= i_bin[BIN_W-1];
`endif
          end
        end
        SHIFT: begin
          // Busy is registered one edge behind the state so it covers
          // exactly the BIN_W shifting edges.
          o_busy <= (cnt != '0);
          if (cnt != '0) begin
            {scr, opr} <= {scr_adj, opr} << 1;
            cnt        <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          o_bcd   <= scr;
          o_valid <= 1'b1;
`ifdef BIN_TO_BCD_SIGNED_EN
          o_neg   <= neg_r;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq
//   Directed bench for bin_to_bcd_seq: an 8-bit/3-digit instance and a
//   16-bit/5-digit instance share clock and reset.
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  bin;
  logic        busy;
  logic        valid;
  logic [11:0] bcd;
  logic        start16;
  logic [15:0] bin16;
  logic        busy16;
  logic        valid16;
  logic [19:0] bcd16;
`ifdef BIN_TO_BCD_SIGNED_EN
  logic        neg;
  logic        neg16;
`endif

  int total;
  int bad;

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_bin   (bin),
    .o_busy  (busy),
    .o_valid (valid),
`ifdef BIN_TO_BCD_SIGNED_EN
    .o_neg   (neg),
`endif
    .o_bcd   (bcd)
  );

  bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) dut16 (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start16),
    .i_bin   (bin16),
    .o_busy  (busy16),
    .o_valid (valid16),
`ifdef BIN_TO_BCD_SIGNED_EN
    .o_neg   (neg16),
`endif
    .o_bcd   (bcd16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; bin = '0; start16 = 1'b0; bin16 = '0;
    tick; tick;
    total++;
    if (busy !== 1'b0 || valid !== 1'b0 || bcd !== 12'h000) begin
      bad++;
      $display("FAIL reset8 got busy=%b valid=%b bcd=%h want 0 0 000", busy, valid, bcd);
    end
    total++;
    if (busy16 !== 1'b0 || valid16 !== 1'b0 || bcd16 !== 20'h00000) begin
      bad++;
      $display("FAIL reset16 got busy=%b valid=%b bcd=%h want 0 0 00000", busy16, valid16, bcd16);
    end
`ifdef BIN_TO_BCD_SIGNED_EN
    total++;
    if (neg !== 1'b0) begin
      bad++;
      $display("FAIL reset_neg got=%b want=0", neg);
    end
`endif
    rst = 1'b0;
    tick;
  endtask

  // One 8-bit conversion accepted at edge k; optionally a second start is
  // presented at edge k+second_at, which must be ignored.
  task automatic test_conv(input logic [7:0] v, input logic [11:0] exp,
                           input logic exp_neg, input int second_at,
                           input string name);
    int nvalid;
    nvalid = 0;
    start = 1'b1; bin = v;
    tick;
    start = 1'b0; bin = ~v;
    for (int j = 1; j <= 14; j++) begin
      tick;
      total++;
      if (busy !== (j <= 8)) begin
        bad++;
        $display("FAIL %s busy edge+%0d got=%b want=%b", name, j, busy, (j <= 8));
      end
      total++;
      if (valid !== (j == 10)) begin
        bad++;
        $display("FAIL %s valid edge+%0d got=%b want=%b", name, j, valid, (j == 10));
      end
      if (valid === 1'b1) nvalid++;
      if (j == 10) begin
        total++;
        if (bcd !== exp) begin
          bad++;
          $display("FAIL %s bcd got=%h want=%h", name, bcd, exp);
        end
`ifdef BIN_TO_BCD_SIGNED_EN
        total++;
        if (neg !== exp_neg) begin
          bad++;
          $display("FAIL %s neg got=%b want=%b", name, neg, exp_neg);
        end
`endif
      end
      start = (j + 1 == second_at);
      if (j + 1 == second_at) bin = v ^ 8'h5A;
    end
    start = 1'b0;
    total++;
    if (nvalid != 1) begin
      bad++;
      $display("FAIL %s pulses got=%0d want=1", name, nvalid);
    end
  endtask

  task automatic test_back_to_back;
    test_conv(8'd42, 12'h042, 1'b0, 3, "ignored_start");
  endtask

  task automatic test_reset_mid;
    int nvalid;
    nvalid = 0;
    start = 1'b1; bin = 8'd100;
    tick;
    start = 1'b0;
    tick; tick; tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    total++;
    if (busy !== 1'b0 || valid !== 1'b0 || bcd !== 12'h000) begin
      bad++;
      $display("FAIL reset_mid got busy=%b valid=%b bcd=%h want 0 0 000", busy, valid, bcd);
    end
    for (int j = 0; j < 14; j++) begin
      tick;
      if (valid === 1'b1 || busy === 1'b1) nvalid++;
    end
    total++;
    if (nvalid != 0) begin
      bad++;
      $display("FAIL reset_mid_after got activity=%0d want=0", nvalid);
    end
    test_conv(8'd37, 12'h037, 1'b0, 0, "after_reset");
  endtask

  task automatic test_rst_start;
    int nact;
    nact = 0;
    rst = 1'b1; start = 1'b1; bin = 8'd55;
    tick;
    rst = 1'b0; start = 1'b0;
    for (int j = 0; j < 12; j++) begin
      tick;
      if (busy === 1'b1 || valid === 1'b1) nact++;
    end
    total++;
    if (nact != 0) begin
      bad++;
      $display("FAIL rst_and_start got activity=%0d want=0", nact);
    end
  endtask

  // Held start on the 16-bit instance: first valid 18 edges after the
  // accepting edge, then one every 19 edges.
  task automatic test_wide;
    int hits[$];
    logic [19:0] exp16;
`ifdef BIN_TO_BCD_SIGNED_EN
    bin16 = 16'h7FFF; exp16 = 20'h32767;
`else
    bin16 = 16'd65535; exp16 = 20'h65535;
`endif
    start16 = 1'b1;
    tick;
    for (int j = 1; j <= 60; j++) begin
      tick;
      if (valid16 === 1'b1) begin
        hits.push_back(j);
        total++;
        if (bcd16 !== exp16) begin
          bad++;
          $display("FAIL wide_bcd edge+%0d got=%h want=%h", j, bcd16, exp16);
        end
      end
    end
    start16 = 1'b0;
    total++;
    if (hits.size() != 3) begin
      bad++;
      $display("FAIL wide_pulses got=%0d want=3", hits.size());
    end else begin
      total++;
      if (hits[0] != 18) begin
        bad++;
        $display("FAIL wide_latency got=%0d want=18", hits[0]);
      end
      total++;
      if (hits[1] - hits[0] != 19 || hits[2] - hits[1] != 19) begin
        bad++;
        $display("FAIL wide_period got=%0d,%0d want=19,19", hits[1] - hits[0], hits[2] - hits[1]);
      end
    end
    for (int j = 0; j < 22; j++) tick;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset;
`ifndef BIN_TO_BCD_SIGNED_EN
    test_conv(8'd255, 12'h255, 1'b0, 0, "u255");
`endif
    test_conv(8'd0,   12'h000, 1'b0, 0, "zero");
    test_conv(8'd100, 12'h100, 1'b0, 0, "hundred");
    test_conv(8'd9,   12'h009, 1'b0, 0, "nine");
    test_back_to_back;
    test_conv(8'd9,   12'h009, 1'b0, 0, "nine_again");
    test_reset_mid;
    test_rst_start;
    test_wide;
`ifdef BIN_TO_BCD_SIGNED_EN
    test_conv(8'h80, 12'h128, 1'b1, 0, "s_min");
    test_conv(8'hFF, 12'h001, 1'b1, 0, "s_m1");
    test_conv(8'h7F, 12'h127, 1'b0, 0, "s_max");
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
